cram_arbiter: RTL

Synchronous sequencer that owns the 512x8 asynchronous colour RAM pins (CEn/OEn/WEn, ADDR, DATA) and shares them between the video colour fetch port and the CPU port. It generates SRAM strobes with programmable wait states, returns read data with a one-cycle ack, and alternates grants when both ports contend. It sits between the tile/colour pipeline, the CPU bus decoder and the CRAM device; the top level owns the DATA tristate.

---
 rtl/cram_pkg.sv | 25 ++
 rtl/cram_arbiter_if.sv | 45 ++++
 rtl/cram_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cram_pkg.sv
// Shared types and defaults for the colour RAM arbiter.
// States, grant owner and default geometry/wait-state values.
package cram_pkg;

    localparam int AW_DEF      = 9;
    localparam int DW_DEF      = 8;
    localparam int RD_WAIT_DEF = 2;
    localparam int WR_WAIT_DEF = 2;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD        = 3'd1;
    localparam logic [2:0] S_WR_SETUP  = 3'd2;
    localparam logic [2:0] S_WR_STROBE = 3'd3;
    localparam logic [2:0] S_WR_HOLD   = 3'd4;

    typedef enum logic {
        GNT_VID = 1'b0,
        GNT_CPU = 1'b1
    } gnt_t;

    function automatic int wait_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cram_arbiter_if.sv
// Bus bundle between requesters, the arbiter and the CRAM pins.
// slave = arbiter side, master = requester / pin-model side.
interface cram_arbiter_if
    import cram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [DW-1:0] vid_data;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    logic [AW-1:0] sram_addr;
    logic          sram_cen;
    logic          sram_oen;
    logic          sram_wen;
    logic [DW-1:0] sram_dout;
    logic          sram_doe;
    logic [DW-1:0] sram_din;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we,
        input  cpu_addr, cpu_wdata, sram_din,
        output vid_ack, vid_data, cpu_ack, cpu_rdata,
        output sram_addr, sram_cen, sram_oen,
        output sram_wen, sram_dout, sram_doe
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we,
        output cpu_addr, cpu_wdata, sram_din,
        input  vid_ack, vid_data, cpu_ack, cpu_rdata,
        input  sram_addr, sram_cen, sram_oen,
        input  sram_wen, sram_dout, sram_doe
    );

endinterface

// File: rtl/cram_arbiter.sv
// Colour RAM sequencer: video/CPU arbitration, SRAM strobes, acks.
// Optional macro CRAM_STALL_CNT_EN adds the cpu_stall_cnt output.
module cram_arbiter
    import cram_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int RD_WAIT = RD_WAIT_DEF,
    parameter int WR_WAIT = WR_WAIT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    cram_arbiter_if.slave  bus
`ifdef CRAM_STALL_CNT_EN
    ,
    output logic [15:0]    cpu_stall_cnt
`endif
);

    localparam int WMAX = wait_max(RD_WAIT, WR_WAIT);
    localparam int CW   = (WMAX > 1) ? $clog2(WMAX) : 1;

    localparam logic [CW-1:0] RD_LAST = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] WR_LAST = CW'(WR_WAIT - 1);

    logic [2:0]    state;
    gnt_t          owner;
    logic          fair;
    logic [CW-1:0] cnt;

    logic grant_vid;
    assign grant_vid = bus.vid_req && (!bus.cpu_req || !fair);

    // Sequencer: state, strobes, latched address/data and ack pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            owner         <= GNT_VID;
            fair          <= 1'b0;
            cnt           <= '0;
            bus.sram_addr <= '0;
            bus.sram_cen  <= 1'b1;
            bus.sram_oen  <= 1'b1;
            bus.sram_wen  <= 1'b1;
            bus.sram_dout <= '0;
            bus.sram_doe  <= 1'b0;
            bus.vid_ack   <= 1'b0;
            bus.vid_data  <= '0;
            bus.cpu_ack   <= 1'b0;
            bus.cpu_rdata <= '0;
        end else begin
            bus.vid_ack <= 1'b0;
            bus.cpu_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (grant_vid) begin
                        owner         <= GNT_VID;
                        fair          <= bus.cpu_req;
                        state         <= S_RD;
                        bus.sram_addr <= bus.vid_addr;
                        bus.sram_cen  <= 1'b0;
                        bus.sram_oen  <= 1'b0;
                    end else if (bus.cpu_req) begin
                        owner         <= GNT_CPU;
                        fair          <= 1'b0;
                        bus.sram_addr <= bus.cpu_addr;
                        bus.sram_cen  <= 1'b0;
                        if (bus.cpu_we) begin
                            state         <= S_WR_SETUP;
                            bus.sram_doe  <= 1'b1;
                            bus.sram_dout <= bus.cpu_wdata;
                        end else begin
                            state        <= S_RD;
                            bus.sram_oen <= 1'b0;
                        end
                    end
                end
                S_RD: begin
                    if (cnt == RD_LAST) begin
                        state        <= S_IDLE;
                        bus.sram_cen <= 1'b1;
                        bus.sram_oen <= 1'b1;
                        if (owner == GNT_VID) begin
                            bus.vid_data <= bus.sram_din;
                            bus.vid_ack  <= 1'b1;
                        end else begin
                            bus.cpu_rdata <= bus.sram_din;
                            bus.cpu_ack   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WR_SETUP: begin
                    state        <= S_WR_STROBE;
                    bus.sram_wen <= 1'b0;
                    cnt          <= '0;
                end
                S_WR_STROBE: begin
                    if (cnt == WR_LAST) begin
                        state        <= S_WR_HOLD;
                        bus.sram_wen <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WR_HOLD: begin
                    state        <= S_IDLE;
                    bus.sram_cen <= 1'b1;
                    bus.sram_doe <= 1'b0;
                    bus.cpu_ack  <= 1'b1;
                end
                default: begin
                    state        <= S_IDLE;
                    bus.sram_cen <= 1'b1;
                    bus.sram_oen <= 1'b1;
                    bus.sram_wen <= 1'b1;
                    bus.sram_doe <= 1'b0;
                end
            endcase
        end
    end

`ifdef CRAM_STALL_CNT_EN
    logic cpu_busy;
    assign cpu_busy = (state != S_IDLE) && (owner == GNT_CPU);

    // Saturating count of cycles the CPU waits while not being serviced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_stall_cnt <= '0;
        end else if (bus.cpu_req && !cpu_busy &&
                     cpu_stall_cnt != 16'hFFFF) begin
            cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
        end
    end
`endif

endmodule
